// File: rtl/transformation_controller_if.sv
// Control bus between the GCN transformation sequencer and its datapath
// (address generator, feature/weight memories, MAC array, scratch pad).
interface transformation_controller_if #(
    parameter int ROW_WIDTH = 3,
    parameter int COL_WIDTH = 2
);
    logic                 start;
    logic                 mac_done;
    logic                 enable_weight_count;
    logic                 enable_feature_count;
    logic                 enable_scratch_pad;
    logic                 read_weight_en;
    logic                 read_feature_en;
    logic                 weight_load;
    logic                 feature_load;
    logic                 mac_start;
    logic                 scratch_wr_en;
    logic [ROW_WIDTH-1:0] scratch_row;
    logic [COL_WIDTH-1:0] scratch_col;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, mac_done,
        output enable_weight_count, enable_feature_count, enable_scratch_pad,
               read_weight_en, read_feature_en, weight_load, feature_load,
               mac_start, scratch_wr_en, scratch_row, scratch_col, busy, done
    );

    modport slave (
        output start, mac_done,
        input  enable_weight_count, enable_feature_count, enable_scratch_pad,
               read_weight_en, read_feature_en, weight_load, feature_load,
               mac_start, scratch_wr_en, scratch_row, scratch_col, busy, done
    );
endinterface

// File: rtl/transformation_controller.sv
// Sequencer for the GCN transformation stage: walks every (row, col) product of
// feature x weight, handshaking memory reads, the MAC array and scratch-pad writes.
module transformation_controller #(
    parameter int FEATURE_ROWS = 6,
    parameter int WEIGHT_COLS  = 3,
    parameter int MEM_LATENCY  = 1,
    parameter int ROW_WIDTH    = $clog2(FEATURE_ROWS),
    parameter int COL_WIDTH    = $clog2(WEIGHT_COLS),
    parameter int LAT_WIDTH    = $clog2(MEM_LATENCY + 1)
) (
    input logic                          clk,
    input logic                          reset,
    transformation_controller_if.master  bus
);
    localparam logic [ROW_WIDTH-1:0] ROW_LAST = ROW_WIDTH'(FEATURE_ROWS - 1);
    localparam logic [COL_WIDTH-1:0] COL_LAST = COL_WIDTH'(WEIGHT_COLS - 1);
    localparam logic [LAT_WIDTH-1:0] LAT_LAST = LAT_WIDTH'(MEM_LATENCY - 1);

    typedef enum logic [3:0] {
        IDLE, WEIGHT_RD, W_WAIT, FEAT_RD, F_WAIT,
        MAC_GO, MAC_WAIT, WRITE, COL_ADV, DONE
    } state_t;

    typedef struct packed {
        logic enable_weight_count;
        logic enable_feature_count;
        logic enable_scratch_pad;
        logic read_weight_en;
        logic read_feature_en;
        logic weight_load;
        logic feature_load;
        logic mac_start;
        logic scratch_wr_en;
        logic busy;
        logic done;
    } strobes_t;

    state_t               state_q, state_d;
    logic [ROW_WIDTH-1:0] row_q, row_d;
    logic [COL_WIDTH-1:0] col_q, col_d;
    logic [LAT_WIDTH-1:0] lat_q, lat_d;
    strobes_t             out_q;

    function automatic strobes_t decode(input state_t s, input logic lat_last);
        strobes_t o;
        o                      = '0;
        o.busy                 = (s != IDLE);
        o.read_weight_en       = (s == WEIGHT_RD);
        o.weight_load          = (s == W_WAIT) && lat_last;
        o.read_feature_en      = (s == FEAT_RD);
        o.enable_scratch_pad   = (s == FEAT_RD);
        o.feature_load         = (s == F_WAIT) && lat_last;
        o.mac_start            = (s == MAC_GO);
        o.scratch_wr_en        = (s == WRITE);
        o.enable_feature_count = (s == WRITE);
        o.enable_weight_count  = (s == COL_ADV);
        o.done                 = (s == DONE);
        return o;
    endfunction

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        lat_d   = lat_q;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = WEIGHT_RD;
                row_d   = '0;
                col_d   = '0;
            end
            WEIGHT_RD: begin
                state_d = W_WAIT;
                lat_d   = '0;
            end
            W_WAIT: begin
                if (lat_q == LAT_LAST) state_d = FEAT_RD;
                else                   lat_d   = lat_q + LAT_WIDTH'(1);
            end
            FEAT_RD: begin
                state_d = F_WAIT;
                lat_d   = '0;
            end
            F_WAIT: begin
                if (lat_q == LAT_LAST) state_d = MAC_GO;
                else                   lat_d   = lat_q + LAT_WIDTH'(1);
            end
            MAC_GO:   state_d = MAC_WAIT;
            MAC_WAIT: if (bus.mac_done) state_d = WRITE;
            WRITE: begin
                if (row_q == ROW_LAST) begin
                    row_d   = '0;
                    state_d = COL_ADV;
                end else begin
                    row_d   = row_q + ROW_WIDTH'(1);
                    state_d = FEAT_RD;
                end
            end
            COL_ADV: begin
                if (col_q == COL_LAST) begin
                    col_d   = '0;
                    state_d = DONE;
                end else begin
                    col_d   = col_q + COL_WIDTH'(1);
                    state_d = WEIGHT_RD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they leave a flop alongside it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            lat_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lat_q   <= lat_d;
            out_q   <= decode(state_d, lat_d == LAT_LAST);
        end
    end

    assign bus.enable_weight_count  = out_q.enable_weight_count;
    assign bus.enable_feature_count = out_q.enable_feature_count;
    assign bus.enable_scratch_pad   = out_q.enable_scratch_pad;
    assign bus.read_weight_en       = out_q.read_weight_en;
    assign bus.read_feature_en      = out_q.read_feature_en;
    assign bus.weight_load          = out_q.weight_load;
    assign bus.feature_load         = out_q.feature_load;
    assign bus.mac_start            = out_q.mac_start;
    assign bus.scratch_wr_en        = out_q.scratch_wr_en;
    assign bus.busy                 = out_q.busy;
    assign bus.done                 = out_q.done;
    assign bus.scratch_row          = row_q;
    assign bus.scratch_col          = col_q;
endmodule

// File: tb/tb_transformation_controller.sv
// Self-checking bench for transformation_controller: a cycle-trace reference model
// built from the run rules, plus measured end-to-end runs with an address-generator model.
module tb_transformation_controller;
    localparam int ROWS = 6;
    localparam int COLS = 3;
    localparam int RW   = 3;
    localparam int CW   = 2;

    typedef struct packed {
        logic ewc, efc, esp, rwe, rfe, wl, fl, ms, swe, busy, done;
        logic [RW-1:0] row;
        logic [CW-1:0] col;
    } outs_t;

    typedef struct {
        logic  rst;
        logic  start;
        logic  mac_done;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset_a, reset_b;
    always #5 clk = ~clk;

    transformation_controller_if #(.ROW_WIDTH(RW), .COL_WIDTH(CW)) a_if ();
    transformation_controller_if #(.ROW_WIDTH(RW), .COL_WIDTH(CW)) b_if ();

    transformation_controller #(.FEATURE_ROWS(ROWS), .WEIGHT_COLS(COLS), .MEM_LATENCY(1))
        dut_a (.clk(clk), .reset(reset_a), .bus(a_if.master));
    transformation_controller #(.FEATURE_ROWS(ROWS), .WEIGHT_COLS(COLS), .MEM_LATENCY(3))
        dut_b (.clk(clk), .reset(reset_b), .bus(b_if.master));

    outs_t out_a, out_b;
    assign out_a = {a_if.enable_weight_count, a_if.enable_feature_count, a_if.enable_scratch_pad,
                    a_if.read_weight_en, a_if.read_feature_en, a_if.weight_load, a_if.feature_load,
                    a_if.mac_start, a_if.scratch_wr_en, a_if.busy, a_if.done,
                    a_if.scratch_row, a_if.scratch_col};
    assign out_b = {b_if.enable_weight_count, b_if.enable_feature_count, b_if.enable_scratch_pad,
                    b_if.read_weight_en, b_if.read_feature_en, b_if.weight_load, b_if.feature_load,
                    b_if.mac_start, b_if.scratch_wr_en, b_if.busy, b_if.done,
                    b_if.scratch_row, b_if.scratch_col};

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs[$];
    int   delay_tab[ROWS][COLS];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else             n_pass++;
    endtask

    task automatic drive(input bit sel, input logic rst, input logic st, input logic md);
        if (sel) begin
            reset_b = rst; b_if.start = st; b_if.mac_done = md;
        end else begin
            reset_a = rst; a_if.start = st; a_if.mac_done = md;
        end
    endtask

    // ---------------- reference model: expected per-cycle trace of one run ----------------
    function automatic logic nz(input int noise);
        if (noise == 1) return 1'b1;
        if (noise == 2) return logic'($urandom_range(0, 1));
        return 1'b0;
    endfunction

    function automatic outs_t base(input int r, input int c);
        outs_t e;
        e      = '0;
        e.busy = 1'b1;
        e.row  = RW'(r);
        e.col  = CW'(c);
        return e;
    endfunction

    function automatic void push(input logic rst, input logic st, input logic md, input outs_t e);
        vec_t v;
        v.rst = rst; v.start = st; v.mac_done = md; v.exp = e;
        vecs.push_back(v);
    endfunction

    // noise 0: quiet, 1: start and spurious mac_done held high, 2: random.
    // A run is cut short by reset in the first F_WAIT cycle of (abort_r, abort_c).
    function automatic void append_run(input int lat, input int noise, input int abort_r, input int abort_c);
        outs_t e;
        push(1'b0, 1'b1, nz(noise), outs_t'('0));
        for (int c = 0; c < COLS; c++) begin
            e = base(0, c); e.rwe = 1'b1;
            push(1'b0, nz(noise), nz(noise), e);
            for (int k = 0; k < lat; k++) begin
                e = base(0, c); e.wl = (k == lat - 1);
                push(1'b0, nz(noise), nz(noise), e);
            end
            for (int r = 0; r < ROWS; r++) begin
                e = base(r, c); e.rfe = 1'b1; e.esp = 1'b1;
                push(1'b0, nz(noise), nz(noise), e);
                for (int k = 0; k < lat; k++) begin
                    e = base(r, c); e.fl = (k == lat - 1);
                    if (r == abort_r && c == abort_c && k == 0) begin
                        push(1'b1, 1'b0, 1'b0, e);
                        return;
                    end
                    push(1'b0, nz(noise), nz(noise), e);
                end
                e = base(r, c); e.ms = 1'b1;
                push(1'b0, nz(noise), nz(noise), e);
                for (int k = 1; k <= delay_tab[r][c]; k++)
                    push(1'b0, nz(noise), (k == delay_tab[r][c]), base(r, c));
                e = base(r, c); e.swe = 1'b1; e.efc = 1'b1;
                push(1'b0, nz(noise), nz(noise), e);
            end
            e = base(0, c); e.ewc = 1'b1;
            push(1'b0, nz(noise), nz(noise), e);
        end
        e = base(0, 0); e.done = 1'b1;
        push(1'b0, nz(noise), nz(noise), e);
    endfunction

    function automatic void fill_delays(input int lo, input int hi);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                delay_tab[r][c] = $urandom_range(hi, lo);
    endfunction

    task automatic apply(input bit sel, input string tag);
        outs_t got;
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            got = sel ? out_b : out_a;
            check($sformatf("%s_vec%0d", tag, i), 64'(got), 64'(vecs[i].exp));
            drive(sel, vecs[i].rst, vecs[i].start, vecs[i].mac_done);
        end
        vecs.delete();
    endtask

    // ---------------- measured run with mac_done responder and address-generator model ----------------
    task automatic run_measured(input bit sel, input int exp_done, input int slow_r, input int slow_c,
                                input int slow_d, input string tag);
        outs_t o;
        int cyc, w, fp, wp, ovl, ms_cyc, cur_d, done_cyc, feat_addr, wt_addr, d;
        bit in_wait;
        cyc = 0; w = 0; fp = 0; wp = 0; ovl = 0; ms_cyc = 0; cur_d = 1; done_cyc = -1;
        feat_addr = 32'h200; wt_addr = 0; in_wait = 1'b0;
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b1, 1'b0);
        while (done_cyc < 0 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            o = sel ? out_b : out_a;
            drive(sel, 1'b0, 1'b0, 1'b0);
            if (cyc == 1) check({tag, "_busy_first"}, 64'(o.busy), 64'(1));
            if (in_wait) begin
                d = cyc - ms_cyc;
                if (d == cur_d) begin
                    drive(sel, 1'b0, 1'b0, 1'b1);
                    in_wait = 1'b0;
                end
                if (cur_d > 1)
                    check({tag, "_hold"}, 64'({o.ewc, o.efc, o.esp, o.rwe, o.rfe, o.wl, o.fl, o.ms,
                                              o.swe, o.busy, o.done}), 64'(11'b00000000010));
            end
            if (o.ms) begin
                ms_cyc  = cyc;
                in_wait = 1'b1;
                cur_d   = (w % ROWS == slow_r && w / ROWS == slow_c) ? slow_d : 1;
            end
            if (o.swe) begin
                check({tag, "_wr_rc"}, 64'({o.row, o.col}), 64'({RW'(w % ROWS), CW'(w / ROWS)}));
                check({tag, "_wr_lat"}, 64'(cyc - ms_cyc), 64'(cur_d + 1));
                w++;
            end
            if (o.rfe) check({tag, "_faddr"}, 64'(feat_addr), 64'(32'h200 + (w % ROWS)));
            if (o.rwe) check({tag, "_waddr"}, 64'(wt_addr), 64'(w / ROWS));
            if (o.efc) fp++;
            if (o.ewc) wp++;
            if (o.efc && o.ewc) ovl++;
            if (o.efc)      feat_addr = (feat_addr == 32'h200 + ROWS - 1) ? 32'h200 : feat_addr + 1;
            else if (o.ewc) wt_addr   = (wt_addr == COLS - 1) ? 0 : wt_addr + 1;
            if (o.done) done_cyc = cyc;
        end
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, "_writes"}, 64'(w), 64'(ROWS * COLS));
        check({tag, "_feat_pulses"}, 64'(fp), 64'(ROWS * COLS));
        check({tag, "_wt_pulses"}, 64'(wp), 64'(COLS));
        check({tag, "_overlap"}, 64'(ovl), 64'(0));
        check({tag, "_faddr_home"}, 64'(feat_addr), 64'(32'h200));
        check({tag, "_waddr_home"}, 64'(wt_addr), 64'(0));
        @(posedge clk); #1;
        o = sel ? out_b : out_a;
        check({tag, "_idle_after"}, 64'(o), 64'(0));
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_a", 64'(out_a), 64'(0));
        check("reset_b", 64'(out_b), 64'(0));
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        run_measured(1'b0, 100, -1, -1, 1, "base");
        run_measured(1'b0, 106, 2, 1, 7, "slow");
        run_measured(1'b1, 142, -1, -1, 1, "lat3");

        // Back-to-back runs with start held high and spurious mac_done.
        fill_delays(1, 1);
        append_run(1, 1, -1, -1);
        append_run(1, 1, -1, -1);
        push(1'b0, 1'b0, 1'b0, outs_t'('0));
        apply(1'b0, "held");

        // Reset in F_WAIT of row 3, column 1, then a fresh clean run.
        append_run(1, 0, 3, 1);
        push(1'b0, 1'b0, 1'b0, outs_t'('0));
        append_run(1, 0, -1, -1);
        push(1'b0, 1'b0, 1'b0, outs_t'('0));
        apply(1'b0, "abort");

        // Randomised MAC latencies and input noise.
        for (int n = 0; n < 4; n++) begin
            fill_delays(1, 4);
            append_run(1, 2, -1, -1);
            for (int k = $urandom_range(2, 1); k > 0; k--) push(1'b0, 1'b0, logic'($urandom_range(0, 1)), outs_t'('0));
            apply(1'b0, $sformatf("rnd%0d", n));
        end
        fill_delays(1, 3);
        append_run(3, 2, -1, -1);
        push(1'b0, 1'b0, 1'b0, outs_t'('0));
        apply(1'b1, "rnd_lat3");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
